// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder and the immediate decoder:
// format codes, opcodes, instruction bit-field positions and the decoder itself.
package instr_encoder_pkg;

    localparam int FMT_W = 3;
    localparam int REG_W = 5;
    localparam int F3_W  = 3;
    localparam int OPC_W = 7;

    typedef enum logic [FMT_W-1:0] {
        FMT_OP_IMM = 3'd0,
        FMT_LOAD   = 3'd1,
        FMT_STORE  = 3'd2,
        FMT_BRANCH = 3'd3,
        FMT_LUI    = 3'd4
    } fmt_e;

    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;

    localparam int OPC_LSB      = 0;
    localparam int RD_LSB       = 7;
    localparam int F3_LSB       = 12;
    localparam int RS1_LSB      = 15;
    localparam int RS2_LSB      = 20;
    localparam int IMM_I_LSB    = 20;
    localparam int IMM_S_HI_LSB = 25;
    localparam int IMM_S_LO_LSB = 7;
    localparam int IMM_U_LSB    = 12;
    localparam int B_IMM11_BIT  = 31;
    localparam int B_IMM10_BIT  = 7;
    localparam int B_HI_LSB     = 25;
    localparam int B_LO_LSB     = 8;

    // Branch immediates stay in halfword units, matching what the encoder accepts.
    function automatic logic [31:0] imm_decode(input logic [31:0] word);
        logic [31:0] imm;
        imm = '0;
        case (word[OPC_LSB +: OPC_W])
            OPC_OP_IMM, OPC_LOAD:
                imm = {{20{word[31]}}, word[IMM_I_LSB +: 12]};
            OPC_STORE:
                imm = {{20{word[31]}}, word[IMM_S_HI_LSB +: 7], word[IMM_S_LO_LSB +: 5]};
            OPC_BRANCH:
                imm = {{21{word[B_IMM11_BIT]}}, word[B_IMM10_BIT],
                       word[B_HI_LSB +: 6], word[B_LO_LSB +: 4]};
            OPC_LUI:
                imm = {word[IMM_U_LSB +: 20], 12'b0};
            default:
                imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-set input, base-address load, encoded-word output and error status
// of the instruction encoder, bundled as one interface.
interface instr_encoder_if
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [FMT_W-1:0]  in_fmt;
    logic [REG_W-1:0]  in_rd;
    logic [REG_W-1:0]  in_rs1;
    logic [REG_W-1:0]  in_rs2;
    logic [F3_W-1:0]   in_funct3;
    logic [31:0]       in_imm;
    logic              base_load;
    logic [ADDR_W-1:0] base_addr;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err;
    logic [7:0]        err_cnt;

    modport master (
        output in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm,
               base_load, base_addr, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, err, err_cnt
    );

    modport slave (
        input  in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm,
               base_load, base_addr, out_ready,
        output in_ready, out_valid, out_instr, out_addr, err, err_cnt
    );
endinterface

// File: rtl/instr_encoder_fifo.sv
// Output FIFO for encoded words; head data reads zero whenever the FIFO is
// empty or held in reset.
module enc_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_req,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] head_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             pop;
    logic             push_ok;

    assign valid     = !rst && (count != '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign pop       = valid && pop_req;
    assign push_ok   = push && (!full || pop);
    assign head_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes field sets into 32-bit instruction words, pairs each with a running
// byte address and queues them; rejected field sets are counted, never queued.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic         clk,
    input  logic         rst,
    instr_encoder_if.slave bus
);
    localparam int ENTRY_W = 32 + ADDR_W;

    logic [31:0]        word;
    logic               legal;
    logic               fits12;
    logic               accept;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_valid;
    logic [ENTRY_W-1:0] head;
    logic [ADDR_W-1:0]  addr_cnt;
    logic [ADDR_W-1:0]  push_addr;
    logic               err_q;
    logic [7:0]         err_cnt_q;

    // Sign-extended 12-bit range: every bit from 31 down to 11 equals bit 11.
    assign fits12 = (bus.in_imm[31:11] == {21{bus.in_imm[11]}});

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (bus.in_fmt)
            FMT_OP_IMM, FMT_LOAD: begin
                word[OPC_LSB +: OPC_W]  = (bus.in_fmt == FMT_LOAD) ? OPC_LOAD : OPC_OP_IMM;
                word[RD_LSB +: REG_W]   = bus.in_rd;
                word[F3_LSB +: F3_W]    = bus.in_funct3;
                word[RS1_LSB +: REG_W]  = bus.in_rs1;
                word[IMM_I_LSB +: 12]   = bus.in_imm[11:0];
                legal                   = fits12;
            end
            FMT_STORE: begin
                word[OPC_LSB +: OPC_W]   = OPC_STORE;
                word[IMM_S_LO_LSB +: 5]  = bus.in_imm[4:0];
                word[F3_LSB +: F3_W]     = bus.in_funct3;
                word[RS1_LSB +: REG_W]   = bus.in_rs1;
                word[RS2_LSB +: REG_W]   = bus.in_rs2;
                word[IMM_S_HI_LSB +: 7]  = bus.in_imm[11:5];
                legal                    = fits12;
            end
            FMT_BRANCH: begin
                word[OPC_LSB +: OPC_W]  = OPC_BRANCH;
                word[B_IMM10_BIT]       = bus.in_imm[10];
                word[B_LO_LSB +: 4]     = bus.in_imm[3:0];
                word[F3_LSB +: F3_W]    = bus.in_funct3;
                word[RS1_LSB +: REG_W]  = bus.in_rs1;
                word[RS2_LSB +: REG_W]  = bus.in_rs2;
                word[B_HI_LSB +: 6]     = bus.in_imm[9:4];
                word[B_IMM11_BIT]       = bus.in_imm[11];
                legal                   = fits12;
            end
            FMT_LUI: begin
                word[OPC_LSB +: OPC_W]  = OPC_LUI;
                word[RD_LSB +: REG_W]   = bus.in_rd;
                word[IMM_U_LSB +: 20]   = bus.in_imm[31:12];
                legal                   = (bus.in_imm[11:0] == 12'd0);
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

    // Ready may stay high when full because a same-cycle pop frees a slot.
    assign pop          = fifo_valid && bus.out_ready;
    assign bus.in_ready = !rst && (!fifo_full || pop);
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = accept && legal;
    assign push_addr    = bus.base_load ? bus.base_addr : addr_cnt;

    enc_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({word, push_addr}),
        .pop_req   (bus.out_ready),
        .full      (fifo_full),
        .valid     (fifo_valid),
        .head_data (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt  <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q <= accept && !legal;
            if (push) begin
                addr_cnt <= push_addr + ADDR_W'(4);
            end else if (bus.base_load) begin
                addr_cnt <= bus.base_addr;
            end
            if (accept && !legal && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign bus.out_valid = fifo_valid;
    assign bus.out_instr = head[ADDR_W +: 32];
    assign bus.out_addr  = head[ADDR_W-1:0];
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomised and directed checks of instr_encoder against an arithmetic
// encoding model and a queue-based FIFO model.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [31:0]       w;
        logic [ADDR_W-1:0] a;
        logic [31:0]       imm;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    ent_t              q[$];
    logic [ADDR_W-1:0] m_addr = '0;
    int                m_errcnt = 0;
    bit                m_err = 1'b0;

    function automatic void ref_encode(input int fmt, input int rd, input int rs1, input int rs2,
                                       input int f3, input logic [31:0] imm,
                                       output logic [31:0] w, output bit ok);
        int s;
        s = $signed(imm);
        w = 32'h0;
        ok = 1'b0;
        case (fmt)
            0, 1: begin
                ok = (s >= -2048) && (s <= 2047);
                w = ((imm & 32'hFFF) << 20) | 32'(rs1 << 15) | 32'(f3 << 12) | 32'(rd << 7)
                    | ((fmt == 0) ? 32'h13 : 32'h03);
            end
            2: begin
                ok = (s >= -2048) && (s <= 2047);
                w = (((imm >> 5) & 32'h7F) << 25) | 32'(rs2 << 20) | 32'(rs1 << 15)
                    | 32'(f3 << 12) | ((imm & 32'h1F) << 7) | 32'h23;
            end
            3: begin
                ok = (s >= -2048) && (s <= 2047);
                w = (((imm >> 11) & 32'h1) << 31) | (((imm >> 4) & 32'h3F) << 25)
                    | 32'(rs2 << 20) | 32'(rs1 << 15) | 32'(f3 << 12)
                    | ((imm & 32'hF) << 8) | (((imm >> 10) & 32'h1) << 7) | 32'h63;
            end
            4: begin
                ok = (imm % 32'd4096) == 32'd0;
                w = (imm & 32'hFFFFF000) | 32'(rd << 7) | 32'h37;
            end
            default: begin
                ok = 1'b0;
                w = 32'h0;
            end
        endcase
    endfunction

    function automatic bit m_ready();
        return !rst && ((q.size() < DEPTH) || ((q.size() > 0) && bus.out_ready));
    endfunction

    // Advance the model and the DUT by one rising edge; returns at edge + 1.
    task automatic tick();
        logic [31:0] w;
        bit ok, pop, rdy, acc;
        ent_t e;
        pop = !rst && (q.size() > 0) && bus.out_ready;
        rdy = m_ready();
        acc = bus.in_valid && rdy;
        ref_encode(int'(bus.in_fmt), int'(bus.in_rd), int'(bus.in_rs1), int'(bus.in_rs2),
                   int'(bus.in_funct3), bus.in_imm, w, ok);
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_addr = '0;
            m_errcnt = 0;
            m_err = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            m_err = acc && !ok;
            if (acc && !ok && m_errcnt < 255) m_errcnt++;
            if (acc && ok) begin
                e.a = bus.base_load ? bus.base_addr : m_addr;
                e.w = w;
                e.imm = bus.in_imm;
                q.push_back(e);
                m_addr = e.a + ADDR_W'(4);
            end else if (bus.base_load) begin
                m_addr = bus.base_addr;
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input int fmt, input int rd, input int rs1, input int rs2,
                         input int f3, input logic [31:0] imm);
        bus.in_valid  = v;
        bus.in_fmt    = 3'(fmt);
        bus.in_rd     = 5'(rd);
        bus.in_rs1    = 5'(rs1);
        bus.in_rs2    = 5'(rs2);
        bus.in_funct3 = 3'(f3);
        bus.in_imm    = imm;
    endtask

    task automatic rand_fields(input bit allow_illegal);
        logic [31:0] r;
        int fmt;
        logic [31:0] imm;
        r = $urandom;
        fmt = int'($urandom_range(0, 4));
        imm = (fmt == 4) ? {r[31:12], 12'h000} : {{20{r[11]}}, r[11:0]};
        if (allow_illegal && $urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 2))
                0: fmt = int'($urandom_range(5, 7));
                1: imm = (fmt == 4) ? (imm | 32'(1 + $urandom_range(0, 4094)))
                                    : (32'd2048 + 32'($urandom_range(0, 100000)));
                default: imm = (fmt == 4) ? (imm | 32'h800) : (32'hFFFFF7FF - 32'($urandom_range(0, 5000)));
            endcase
        end
        drive(1'b1, fmt, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 7)), imm);
    endtask

    // Sends n legal words with the consumer always ready, recording popped addresses.
    task automatic run_words(input int n, output logic [ADDR_W-1:0] addrs[8], output int got);
        int sent;
        bit acc;
        sent = 0;
        got = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < n * 10 + 20 && got < n; c++) begin
            if (sent < n) rand_fields(1'b0);
            else bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid && got < 8) begin
                addrs[got] = bus.out_addr;
                got++;
            end
            acc = bus.in_valid && m_ready();
            if (acc) sent++;
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        bus.base_load = 1'b0;
        bus.base_addr = '0;
        drive(1'b1, 0, 1, 2, 3, 0, 32'd5);
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        checks++; if (bus.out_instr !== 32'h0 || bus.out_addr !== '0) begin errors++; $display("FAIL reset_out_data got %h/%0d want 0/0", bus.out_instr, bus.out_addr); end
        checks++; if (bus.err !== 1'b0 || bus.err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err got %b/%0d want 0/0", bus.err, bus.err_cnt); end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b want 1", bus.in_ready); end
    endtask

    task automatic test_imm_range();
        logic [11:0] hi;
        bus.out_ready = 1'b1;
        drive(1'b1, 0, 1, 2, 0, 0, 32'd2048);
        tick();
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.err !== 1'b1 || bus.err_cnt !== 8'd1) begin errors++; $display("FAIL imm2048_err got %b/%0d want 1/1", bus.err, bus.err_cnt); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL imm2048_no_push got %b want 0", bus.out_valid); end
        tick();
        checks++; if (bus.err !== 1'b0 || bus.err_cnt !== 8'd1) begin errors++; $display("FAIL imm2048_err_pulse got %b/%0d want 0/1", bus.err, bus.err_cnt); end
        drive(1'b1, 0, 3, 4, 0, 0, 32'hFFFFF800);
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        #1;
        hi = bus.out_instr[31:20];
        checks++; if (bus.out_valid !== 1'b1 || hi !== 12'h800) begin errors++; $display("FAIL imm_neg2048 got %b/%h want 1/800", bus.out_valid, hi); end
        checks++; if (bus.out_addr !== 10'd0 || bus.out_instr !== q[0].w) begin errors++; $display("FAIL imm_neg2048_word got %h@%0d want %h@0", bus.out_instr, bus.out_addr, q[0].w); end
        bus.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_lui();
        drive(1'b1, 4, 5, 0, 0, 0, 32'h12345000);
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_instr !== 32'h123452B7) begin errors++; $display("FAIL lui_word got %h want 123452b7", bus.out_instr); end
        tick();
        checks++; if (bus.out_instr !== 32'h123452B7 || bus.out_addr !== 10'd4) begin errors++; $display("FAIL lui_stall got %h@%0d want 123452b7@4", bus.out_instr, bus.out_addr); end
        bus.out_ready = 1'b1;
        drive(1'b1, 4, 5, 0, 0, 0, 32'h12345001);
        tick();
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.err !== 1'b1 || bus.err_cnt !== 8'd2) begin errors++; $display("FAIL lui_low_bits_err got %b/%0d want 1/2", bus.err, bus.err_cnt); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lui_low_bits_no_push got %b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        logic [ADDR_W-1:0] got_a[8];
        int n;
        bit acc;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_fields(1'b0);
            #1;
            checks++;
            if (bus.in_ready !== (i < 4)) begin errors++; $display("FAIL bp_ready_%0d got %b want %b", i, bus.in_ready, (i < 4)); end
            tick();
        end
        held = bus.out_instr;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.out_instr !== held || bus.out_addr !== 10'd0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall got %h@%0d rdy %b want %h@0 rdy 0", bus.out_instr, bus.out_addr, bus.in_ready, held); end
        end
        bus.out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 30 && n < 5; c++) begin
            #1;
            if (bus.out_valid) begin
                got_a[n] = bus.out_addr;
                n++;
            end
            acc = bus.in_valid && m_ready();
            tick();
            if (acc) bus.in_valid = 1'b0;
        end
        checks++; if (n !== 5) begin errors++; $display("FAIL bp_drain_count got %0d want 5", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (got_a[i] !== ADDR_W'(i * 4)) begin errors++; $display("FAIL bp_order_%0d got %0d want %0d", i, got_a[i], i * 4); end
        end
    endtask

    task automatic test_base_wrap();
        logic [ADDR_W-1:0] got_a[8];
        int n;
        bus.in_valid = 1'b0;
        bus.base_load = 1'b1;
        bus.base_addr = 10'd1020;
        tick();
        bus.base_load = 1'b0;
        run_words(2, got_a, n);
        checks++; if (n !== 2 || got_a[0] !== 10'd1020 || got_a[1] !== 10'd0) begin errors++; $display("FAIL base_wrap got n=%0d %0d,%0d want 1020,0", n, got_a[0], got_a[1]); end
        bus.out_ready = 1'b0;
        rand_fields(1'b0);
        bus.base_load = 1'b1;
        bus.base_addr = 10'd100;
        tick();
        bus.base_load = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_addr !== 10'd100) begin errors++; $display("FAIL base_with_accept got %0d want 100", bus.out_addr); end
        bus.out_ready = 1'b1;
        tick();
        run_words(1, got_a, n);
        checks++; if (n !== 1 || got_a[0] !== 10'd104) begin errors++; $display("FAIL base_after_accept got n=%0d %0d want 104", n, got_a[0]); end
    endtask

    task automatic test_reset_midstream();
        logic [ADDR_W-1:0] got_a[8];
        int n;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_fields(1'b0);
            tick();
        end
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || q.size() != 3) begin errors++; $display("FAIL mid_fill got %b want 1", bus.out_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0) begin errors++; $display("FAIL mid_reset_flush got %b/%h want 0/0", bus.out_valid, bus.out_instr); end
        run_words(1, got_a, n);
        checks++; if (n !== 1 || got_a[0] !== 10'd0) begin errors++; $display("FAIL mid_reset_addr got n=%0d %0d want 0", n, got_a[0]); end
    endtask

    task automatic test_err_saturation();
        bus.out_ready = 1'b1;
        drive(1'b1, 5, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 100) begin
                checks++; if (bus.err !== 1'b1 || bus.err_cnt !== 8'(m_errcnt)) begin errors++; $display("FAIL err_count_mid got %b/%0d want 1/%0d", bus.err, bus.err_cnt, m_errcnt); end
            end
        end
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.err_cnt !== 8'd255) begin errors++; $display("FAIL err_cnt_saturate got %0d want 255", bus.err_cnt); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL err_no_push got %b want 0", bus.out_valid); end
        tick();
    endtask

    task automatic test_random();
        int decoded;
        logic [31:0] dimm;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b0;
        decoded = 0;
        for (int c = 0; c < 20000 && decoded < 1000; c++) begin
            rand_fields(1'b1);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.base_load = ($urandom_range(0, 49) == 0);
            bus.base_addr = ADDR_W'($urandom);
            #1;
            checks++; if (bus.in_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready c=%0d got %b want %b", c, bus.in_ready, m_ready()); end
            checks++; if (bus.out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid c=%0d got %b want %b", c, bus.out_valid, q.size() != 0); end
            checks++; if (bus.err !== m_err || bus.err_cnt !== 8'(m_errcnt)) begin errors++; $display("FAIL rnd_err c=%0d got %b/%0d want %b/%0d", c, bus.err, bus.err_cnt, m_err, m_errcnt); end
            if (q.size() != 0) begin
                checks++; if (bus.out_instr !== q[0].w || bus.out_addr !== q[0].a) begin errors++; $display("FAIL rnd_head c=%0d got %h@%0d want %h@%0d", c, bus.out_instr, bus.out_addr, q[0].w, q[0].a); end
                if (bus.out_ready) begin
                    dimm = imm_decode(bus.out_instr);
                    checks++; if (dimm !== q[0].imm) begin errors++; $display("FAIL rnd_roundtrip c=%0d word %h got %h want %h", c, bus.out_instr, dimm, q[0].imm); end
                    decoded++;
                end
            end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.base_load = 1'b0;
        checks++; if (decoded < 1000) begin errors++; $display("FAIL rnd_budget got %0d want 1000 decoded words", decoded); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_fmt    = '0;
        bus.in_rd     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_funct3 = '0;
        bus.in_imm    = '0;
        bus.base_load = 1'b0;
        bus.base_addr = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_imm_range();
        test_lui();
        test_backpressure();
        test_base_wrap();
        test_reset_midstream();
        test_err_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 10: byte-address width of the emitted-word address counter.
REQ-002 Parameter DEPTH, default 4: output FIFO entries; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  field set presented.
REQ-006 in_ready  output  1  encoder accepts the field set this cycle.
REQ-007 in_fmt  input  3  format: 0=OP-IMM, 1=LOAD, 2=STORE, 3=BRANCH, 4=LUI; 5-7 illegal.
REQ-008 in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-009 in_funct3  input  3  funct3 field.
REQ-010 in_imm  input  32  signed immediate, or the upper-immediate value for LUI.
REQ-011 base_load  input  1  load the address counter from base_addr (no handshake).
REQ-012 base_addr  input  ADDR_W  new counter value.
REQ-013 out_valid  output  1  FIFO non-empty.
REQ-014 out_ready  input  1  consumer takes the head word.
REQ-015 out_instr  output  32  encoded word at the FIFO head.
REQ-016 out_addr  output  ADDR_W  byte address paired with out_instr.
REQ-017 err  output  1  one-cycle pulse when an accepted field set is rejected.
REQ-018 err_cnt  output  8  count of rejections; saturates at 255.

Function
REQ-019 Accept occurs when in_valid and in_ready are both high; in_ready SHALL be high iff the FIFO is not full, or it is full and a pop occurs in the same cycle.
REQ-020 Opcodes: OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111.
REQ-021 OP-IMM/LOAD: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd; legal iff imm[31:11] are all equal.
REQ-022 STORE: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=imm[4:0]; legal iff imm[31:11] are all equal.
REQ-023 BRANCH: imm is a halfword offset, with [31]=imm[11], [7]=imm[10], [30:25]=imm[9:4], [11:8]=imm[3:0], plus rs2, rs1 and funct3 as for STORE; legal iff imm[31:11] are all equal.
REQ-024 LUI: [31:12]=imm[31:12], [11:7]=rd; legal iff imm[11:0]==0.
REQ-025 An illegal fmt or range violation SHALL cause the following:
- no FIFO push;
- err pulses in the cycle after the accept;
- err_cnt increments, saturating at 255;
- the address counter does not advance.
REQ-026 A legal accept SHALL push {word, addr_cnt} into the FIFO and advance addr_cnt by 4, modulo 2^ADDR_W; wrap from 2^ADDR_W-4 to 0 is silent.
REQ-027 Latency: a word accepted in cycle N is visible on out_valid/out_instr in cycle N+1 when the FIFO was empty.
REQ-028 Push and pop in the same cycle SHALL keep the occupancy unchanged and are permitted when the FIFO is full.
REQ-029 out_instr and out_addr SHALL hold stable while out_valid is high and out_ready is low.
REQ-030 If base_load coincides with a legal accept, the pushed word SHALL take address base_addr, and addr_cnt becomes base_addr+4.
REQ-031 FIFO order SHALL be strict first-in, first-out; no word is lost or duplicated.

Reset
REQ-032 While rst is high, the block SHALL force:
- FIFO empty and out_valid=0;
- in_ready=0;
- addr_cnt=0, err=0, err_cnt=0.
REQ-033 out_instr and out_addr SHALL read 0 during reset.
REQ-034 Reset mid-stream SHALL discard all FIFO contents.
REQ-035 in_ready SHALL rise in the first cycle after rst falls.

Structure
REQ-036 The opcode constants, the fmt encodings and the instruction bit-field positions SHALL live in a shared package that is also used by the immediate decoder.
REQ-037 The FIFO SHALL be a single sub-module, enc_fifo, parameterised by width and DEPTH.

Verification
REQ-038 Round-trip test: at least 1000 random legal field sets SHALL be encoded and fed to the team's immediate decoder; the decoded immediate SHALL equal the sign-extended in_imm, or imm[31:12] with zeros below for LUI.
REQ-039 OP-IMM with imm=2048 -> no push, err pulses for one cycle, err_cnt=1. OP-IMM with imm=-2048 -> out_instr[31:20]=12'h800.
REQ-040 LUI with imm=32'h12345000 and rd=5 -> out_instr=32'h123452B7. LUI with imm=32'h12345001 -> err.
REQ-041 out_ready held low through 5 legal accepts -> in_ready=0 after the 4th accept. Then out_ready high -> addresses 0, 4, 8, 12, 16 in order.
REQ-042 base_load=1 with base_addr=1020 (ADDR_W=10), followed by 2 legal accepts -> addresses 1020 and 0.
REQ-043 rst asserted while the FIFO holds 3 words -> out_valid=0 the next cycle, and the next accepted word is emitted at address 0.
